sprite_engine: RTL and testbench
================================

# sprite_engine

Parametrised hardware sprite engine for the TinyQV video peripheral: renders up to NUM_SPRITES 8x8 1-bpp sprites over the video timing stream and outputs a per-pixel colour plus a valid flag. The object table is double-buffered: the host writes a staging table, and the staging table is copied to the active table at the next vsync rising edge after the host sets COMMIT. It also has a sticky frame interrupt and sprite-collision detection. It sits between the video_controller timing outputs and the uo_out colour mux.

## Interface
- NUM_SPRITES, default 4: number of object slots, legal range 1..8.
- NUM_BITMAPS, default 2: number of 8x8 bitmaps, legal range 1..3.
- COLOR_BITS, default 6: colour width (RRGGBB), legal range 1..6.
- clk  in  1  peripheral clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  6  byte address within the peripheral.
- data_in  in  32  write data (bottom 8/16/32 bits valid).
- data_write_n  in  2  11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit.
- data_read_n  in  2  read strobe; unused apart from lint.
- data_out  out  32  read data, combinational from address.
- data_ready  out  1  tied to 1.
- pix_x, pix_y  in  10 each  current pixel coordinates from video_controller.
- visible  in  1  active video area.
- vsync  in  1  vertical sync, positive polarity.
- pixel_color  out  COLOR_BITS  registered colour of the winning sprite.
- pixel_valid  out  1  registered; a sprite covers this pixel.
- user_interrupt  out  1  sticky frame interrupt, gated by IRQ_EN.

## Operation
- Register map, byte addresses:
  - 0x00+4i: object i, staging table. Word layout: [9:0] x, [19:10] y, [25:20] colour (low COLOR_BITS used), [27:26] bitmap index, [31] enable.
  - 0x20+8b: bitmap b, 8 row bytes. Byte r is row r; bit c is column c, LSB = leftmost.
  - 0x38: CONTROL. Bit0 ENABLE, bit1 COMMIT, bit2 IRQ_EN.
  - 0x3C: STATUS. Bit0 FRAME (sticky), bit1 COLLIDE (sticky), bit2 SWAPPED (sticky). Write 1 to a bit to clear it.
- Writes:
  - Address bits [1:0] are ignored; writes are word-aligned.
  - An 8/16/32-bit write updates bytes 0/0-1/0-3 of the addressed word.
  - Object slots with i >= NUM_SPRITES, bitmaps with b >= NUM_BITMAPS, and all unmapped addresses ignore writes and read 0.
- Reads:
  - Objects read from the staging table, never the active table.
  - Bitmaps, CONTROL and STATUS read back as stored, zero-extended.
- Swap:
  - vs_rise = vsync & ~vsync_d, where vsync_d is a register with reset value 0.
  - On vs_rise with COMMIT=1: all active entries are loaded from staging in that single cycle, COMMIT clears and SWAPPED sets.
  - On every vs_rise, FRAME sets.
- Render, per sprite i, using the active table:
  - dx = (pix_x - x) mod 1024; dy = (pix_y - y) mod 1024.
  - hit_i = enable & (dx<8) & (dy<8) & (index<NUM_BITMAPS) & bitmap[index][dy][dx].
- Priority and collision:
  - The lowest i with hit_i wins.
  - When visible & ENABLE and two or more hit_i are set, COLLIDE sets.
- user_interrupt = FRAME & IRQ_EN.

## Timing
- Reset (asynchronous) clears all tables, CONTROL, STATUS, vsync_d, pixel_color, pixel_valid and user_interrupt to 0.
- Render latency is 1 cycle: pixel_valid and pixel_color registered at edge N reflect pix_x/pix_y/visible sampled at edge N.
- pixel_valid = visible & ENABLE & (any hit_i). pixel_color = 0 whenever pixel_valid = 0.
- Wrap-around is required behaviour: a sprite at x=1020 covers pix_x 1020..1023 and 0..3.
- Swap and write in the same cycle: the active table receives the pre-write staging value; the write lands in staging.
- A host write setting COMMIT in the same cycle as vs_rise: the swap is evaluated with the old COMMIT=0, COMMIT ends at 1, and the swap happens at the next vs_rise.
- STATUS set and clear in the same cycle: set wins.
- A reads-while-swapping hazard does not exist: reads always return staging.

## Test plan
- Reset mid-frame with ENABLE=1 and a sprite covering the pixel -> pixel_valid=0, pixel_color=0, user_interrupt=0 asynchronously; all reads return 0.
- Object0 = {en=1, x=100, y=50, colour=0x2A, index 0}, bitmap0 row0 = 0x01, COMMIT=1, one vsync pulse -> SWAPPED=1, COMMIT=0; at pix (100,50) with visible, pixel_valid=1 and colour=0x2A one cycle later; at (101,50), pixel_valid=0.
- Write object0 staging without COMMIT across two vsyncs -> render unchanged, FRAME set, SWAPPED remains 0.
- Sprites 0 and 1 both opaque at (10,10) with colours 0x03 and 0x30 -> pixel_color=0x03 and COLLIDE=1; write 0x2 to STATUS -> COLLIDE=0.
- Sprite x=1020 with bitmap row 0xFF -> pixel_valid=1 at pix_x 1022 and pix_x 2, and 0 at pix_x 4.
- IRQ_EN=1, vsync rise -> user_interrupt=1; a STATUS write of 0x1 in the same cycle as the next vs_rise -> FRAME remains 1.

Source files
------------

// File: rtl/sprite_engine.sv
// Sprite engine: double-buffered object table, 8x8 1-bpp bitmaps, per-pixel
// priority render with one registered output stage, sticky frame/collision status.
module sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int NUM_BITMAPS = 2,
  parameter int COLOR_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            address,
  input  logic [31:0]           data_in,
  input  logic [1:0]            data_write_n,
  input  logic [1:0]            data_read_n,
  output logic [31:0]           data_out,
  output logic                  data_ready,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  visible,
  input  logic                  vsync,
  output logic [COLOR_BITS-1:0] pixel_color,
  output logic                  pixel_valid,
  output logic                  user_interrupt
);
  logic [31:0]           stg     [NUM_SPRITES];
  logic [63:0]           bm      [NUM_BITMAPS];
  logic                  act_en  [NUM_SPRITES];
  logic [9:0]            act_x   [NUM_SPRITES];
  logic [9:0]            act_y   [NUM_SPRITES];
  logic [1:0]            act_idx [NUM_SPRITES];
  logic [COLOR_BITS-1:0] act_col [NUM_SPRITES];

  logic [2:0]             ctrl, ctrl_n, status, status_n;
  logic                   vsync_d, vs_rise, swap, wr;
  logic [3:0]             word;
  logic [31:0]            wmask;
  logic [NUM_SPRITES-1:0] hit_p0;
  logic [COLOR_BITS-1:0]  win_col_p0;
  logic                   vld_p0, seen, multi, collide_set;
  logic                   unused_ok;

  assign data_ready     = 1'b1;
  assign wr             = (data_write_n != 2'b11);
  assign word           = address[5:2];
  assign vs_rise        = vsync & ~vsync_d;
  assign swap           = vs_rise & ctrl[1];
  assign user_interrupt = status[0] & ctrl[2];
  assign unused_ok      = &{1'b0, data_read_n, address[1:0]};

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [31:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  always_comb begin
    case (data_write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      2'b10:   wmask = 32'hFFFF_FFFF;
      default: wmask = 32'h0000_0000;
    endcase
  end

  // Per-sprite hit test; an out-of-range bitmap index selects an all-zero shape.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [9:0]  dx, dy;
    logic [63:0] shape;
    assign dx = pix_x - act_x[i];
    assign dy = pix_y - act_y[i];
    always_comb begin
      shape = '0;
      for (int b = 0; b < NUM_BITMAPS; b++)
        if (act_idx[i] == 2'(b)) shape = bm[b];
    end
    assign hit_p0[i] = act_en[i] && (dx[9:3] == 7'd0) && (dy[9:3] == 7'd0)
                       && shape[{dy[2:0], dx[2:0]}];
  end

  always_comb begin
    win_col_p0 = '0;
    seen       = 1'b0;
    multi      = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (hit_p0[i]) win_col_p0 = act_col[i];
    for (int i = 0; i < NUM_SPRITES; i++) begin
      multi = multi | (seen & hit_p0[i]);
      seen  = seen | hit_p0[i];
    end
  end

  assign vld_p0      = visible & ctrl[0] & (|hit_p0);
  assign collide_set = visible & ctrl[0] & multi;

  // A host COMMIT write on the swap edge overrides the swap's auto-clear.
  always_comb begin
    ctrl_n = ctrl;
    if (swap) ctrl_n[1] = 1'b0;
    if (wr && word == 4'd14) ctrl_n = data_in[2:0];
    status_n = status;
    if (wr && word == 4'd15) status_n = status & ~data_in[2:0];
    status_n = status_n | {swap, collide_set, vs_rise};
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      if (word == 4'(i)) data_out = stg[i];
    for (int b = 0; b < NUM_BITMAPS; b++) begin
      if (word == 4'(8 + 2 * b)) data_out = bm[b][31:0];
      if (word == 4'(9 + 2 * b)) data_out = bm[b][63:32];
    end
    if (word == 4'd14) data_out = {29'd0, ctrl};
    if (word == 4'd15) data_out = {29'd0, status};
  end

  // Stage p0 -> p1: swap, host writes and the registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      ctrl        <= '0;
      status      <= '0;
      pixel_valid <= 1'b0;
      pixel_color <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        stg[i]     <= '0;
        act_en[i]  <= 1'b0;
        act_x[i]   <= '0;
        act_y[i]   <= '0;
        act_idx[i] <= '0;
        act_col[i] <= '0;
      end
      for (int b = 0; b < NUM_BITMAPS; b++) bm[b] <= '0;
    end else begin
      vsync_d     <= vsync;
      ctrl        <= ctrl_n;
      status      <= status_n;
      pixel_valid <= vld_p0;
      pixel_color <= vld_p0 ? win_col_p0 : '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (swap) begin
          act_x[i]   <= stg[i][9:0];
          act_y[i]   <= stg[i][19:10];
          act_col[i] <= stg[i][20 +: COLOR_BITS];
          act_idx[i] <= stg[i][27:26];
          act_en[i]  <= stg[i][31];
        end
        if (wr && word == 4'(i)) stg[i] <= merge_word(stg[i], data_in, wmask);
      end
      for (int b = 0; b < NUM_BITMAPS; b++) begin
        if (wr && word == 4'(8 + 2 * b)) bm[b][31:0]  <= merge_word(bm[b][31:0], data_in, wmask);
        if (wr && word == 4'(9 + 2 * b)) bm[b][63:32] <= merge_word(bm[b][63:32], data_in, wmask);
      end
    end
  end
endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: register access, swap, render, priority,
// wrap-around, interrupt and asynchronous reset.
module tb_sprite_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        visible = 1'b0, vsync = 1'b0;
  logic [5:0]  pixel_color;
  logic        pixel_valid, user_interrupt;

  int n_vec = 0;
  int n_err = 0;

  sprite_engine #(.NUM_SPRITES(4), .NUM_BITMAPS(2), .COLOR_BITS(6)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .pix_x(pix_x), .pix_y(pix_y), .visible(visible),
    .vsync(vsync), .pixel_color(pixel_color), .pixel_valid(pixel_valid),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    address = a; data_in = d; data_write_n = sz;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = data_out;
  endtask

  task automatic vsync_pulse();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
  endtask

  task automatic render(input logic [9:0] x, input logic [9:0] y,
                        output logic v, output logic [5:0] c);
    @(negedge clk); pix_x = x; pix_y = y; visible = 1'b1;
    @(negedge clk); v = pixel_valid; c = pixel_color; visible = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_vec++; if (pixel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0d want 0", pixel_valid); end
    n_vec++; if (pixel_color !== 6'h00) begin n_err++; $display("FAIL reset_color got %h want 00", pixel_color); end
    n_vec++; if (user_interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq got %0d want 0", user_interrupt); end
    n_vec++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL data_ready got %0d want 1", data_ready); end
    @(negedge clk); reset = 1'b0;
    bus_read(6'h38, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", d); end
    bus_read(6'h3C, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status got %h want 0", d); end
  endtask

  task automatic test_reg_access();
    logic [31:0] d;
    bus_write(6'h28, 32'h1122_3344, 2'b10);
    bus_write(6'h29, 32'hAABB_CCDD, 2'b00);
    bus_read(6'h28, d);
    n_vec++; if (d !== 32'h1122_33DD) begin n_err++; $display("FAIL byte_write got %h want 112233dd", d); end
    bus_write(6'h28, 32'h0000_5566, 2'b01);
    bus_read(6'h2B, d);
    n_vec++; if (d !== 32'h1122_5566) begin n_err++; $display("FAIL half_write got %h want 11225566", d); end
    bus_write(6'h10, 32'hFFFF_FFFF, 2'b10);
    bus_read(6'h10, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL slot4_unmapped got %h want 0", d); end
    bus_write(6'h30, 32'hFFFF_FFFF, 2'b10);
    bus_read(6'h30, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL bitmap2_unmapped got %h want 0", d); end
  endtask

  task automatic test_basic_swap();
    logic [31:0] d; logic v; logic [5:0] c;
    bus_write(6'h00, 32'h82A0_C864, 2'b10);
    bus_write(6'h20, 32'h0000_0001, 2'b10);
    bus_write(6'h38, 32'h3, 2'b10);
    render(10'd100, 10'd50, v, c);
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL pre_swap_valid got %0d want 0", v); end
    vsync_pulse();
    bus_read(6'h3C, d);
    n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL swap_status got %h want 5", d); end
    bus_read(6'h38, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL commit_clear got %h want 1", d); end
    bus_read(6'h00, d);
    n_vec++; if (d !== 32'h82A0_C864) begin n_err++; $display("FAIL obj0_read got %h want 82a0c864", d); end
    render(10'd100, 10'd50, v, c);
    n_vec++; if (v !== 1'b1 || c !== 6'h2A) begin n_err++; $display("FAIL hit_100_50 got v=%0d c=%h want v=1 c=2a", v, c); end
    render(10'd101, 10'd50, v, c);
    n_vec++; if (v !== 1'b0 || c !== 6'h00) begin n_err++; $display("FAIL miss_101_50 got v=%0d c=%h want v=0 c=00", v, c); end
    render(10'd100, 10'd51, v, c);
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL miss_row1 got %0d want 0", v); end
    bus_write(6'h3C, 32'h7, 2'b10);
  endtask

  task automatic test_no_commit();
    logic [31:0] d; logic v; logic [5:0] c;
    bus_write(6'h00, 32'h82A0_C8C8, 2'b10);
    vsync_pulse();
    vsync_pulse();
    render(10'd100, 10'd50, v, c);
    n_vec++; if (v !== 1'b1 || c !== 6'h2A) begin n_err++; $display("FAIL nocommit_old got v=%0d c=%h want v=1 c=2a", v, c); end
    render(10'd200, 10'd50, v, c);
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL nocommit_new got %0d want 0", v); end
    bus_read(6'h3C, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL nocommit_status got %h want 1", d); end
    bus_read(6'h00, d);
    n_vec++; if (d !== 32'h82A0_C8C8) begin n_err++; $display("FAIL staging_read got %h want 82a0c8c8", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d; logic v; logic [5:0] c;
    bus_write(6'h00, 32'h8030_280A, 2'b10);
    bus_write(6'h04, 32'h8300_280A, 2'b10);
    bus_write(6'h38, 32'h3, 2'b10);
    vsync_pulse();
    bus_write(6'h3C, 32'h7, 2'b10);
    render(10'd10, 10'd10, v, c);
    n_vec++; if (v !== 1'b1 || c !== 6'h03) begin n_err++; $display("FAIL priority got v=%0d c=%h want v=1 c=03", v, c); end
    bus_read(6'h3C, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL collide_set got %h want 2", d); end
    bus_write(6'h3C, 32'h2, 2'b10);
    bus_read(6'h3C, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL collide_clear got %h want 0", d); end
  endtask

  task automatic test_wrap();
    logic v; logic [5:0] c;
    bus_write(6'h00, 32'h8030_2BFC, 2'b10);
    bus_write(6'h04, 32'h0, 2'b10);
    bus_write(6'h20, 32'h0000_00FF, 2'b10);
    bus_write(6'h38, 32'h3, 2'b10);
    vsync_pulse();
    render(10'd1022, 10'd10, v, c);
    n_vec++; if (v !== 1'b1 || c !== 6'h03) begin n_err++; $display("FAIL wrap_1022 got v=%0d c=%h want v=1 c=03", v, c); end
    render(10'd2, 10'd10, v, c);
    n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL wrap_2 got %0d want 1", v); end
    render(10'd4, 10'd10, v, c);
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL wrap_4 got %0d want 0", v); end
    render(10'd1019, 10'd10, v, c);
    n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL wrap_1019 got %0d want 0", v); end
  endtask

  task automatic test_commit_race();
    logic [31:0] d; logic v; logic [5:0] c;
    bus_write(6'h3C, 32'h7, 2'b10);
    bus_write(6'h00, 32'h8030_29F4, 2'b10);
    @(negedge clk);
    vsync = 1'b1; address = 6'h38; data_in = 32'h3; data_write_n = 2'b10;
    @(negedge clk);
    vsync = 1'b0; data_write_n = 2'b11;
    bus_read(6'h38, d);
    n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL race_commit got %h want 3", d); end
    bus_read(6'h3C, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL race_status got %h want 1", d); end
    render(10'd1022, 10'd10, v, c);
    n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL race_old_active got %0d want 1", v); end
    vsync_pulse();
    render(10'd500, 10'd10, v, c);
    n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL race_new_active got %0d want 1", v); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(6'h38, 32'h5, 2'b10);
    bus_write(6'h3C, 32'h7, 2'b10);
    #1;
    n_vec++; if (user_interrupt !== 1'b0) begin n_err++; $display("FAIL irq_idle got %0d want 0", user_interrupt); end
    vsync_pulse();
    n_vec++; if (user_interrupt !== 1'b1) begin n_err++; $display("FAIL irq_set got %0d want 1", user_interrupt); end
    @(negedge clk);
    vsync = 1'b1; address = 6'h3C; data_in = 32'h1; data_write_n = 2'b10;
    @(negedge clk);
    vsync = 1'b0; data_write_n = 2'b11;
    bus_read(6'h3C, d);
    n_vec++; if (d[0] !== 1'b1) begin n_err++; $display("FAIL set_wins got %0d want 1", d[0]); end
    n_vec++; if (user_interrupt !== 1'b1) begin n_err++; $display("FAIL irq_held got %0d want 1", user_interrupt); end
    bus_write(6'h3C, 32'h1, 2'b10);
    #1;
    n_vec++; if (user_interrupt !== 1'b0) begin n_err++; $display("FAIL irq_clear got %0d want 0", user_interrupt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    vsync_pulse();
    @(negedge clk); pix_x = 10'd500; pix_y = 10'd10; visible = 1'b1;
    @(negedge clk);
    n_vec++; if (pixel_valid !== 1'b1 || user_interrupt !== 1'b1) begin n_err++; $display("FAIL pre_reset got v=%0d irq=%0d want 1 1", pixel_valid, user_interrupt); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (pixel_valid !== 1'b0 || pixel_color !== 6'h00 || user_interrupt !== 1'b0) begin
      n_err++; $display("FAIL async_reset got v=%0d c=%h irq=%0d want 0 00 0", pixel_valid, pixel_color, user_interrupt); end
    bus_read(6'h00, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_obj0 got %h want 0", d); end
    bus_read(6'h20, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_bm0 got %h want 0", d); end
    bus_read(6'h38, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl2 got %h want 0", d); end
    visible = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #12;
    test_reset();
    test_reg_access();
    test_basic_swap();
    test_no_commit();
    test_priority();
    test_wrap();
    test_commit_race();
    test_irq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
